// File: rtl/ar_forward_slice.sv
// AR-channel forward slice: unpacks a packed AR bundle through a fully registered two-entry skid buffer.
// Optional burst-rule checker is enabled by defining AR_FORWARD_CHECK_EN.
module ar_forward_slice #(
  parameter int ID_W       = 8,
  parameter int ADDR_W     = 36,
  parameter int USER_W     = 4,
  parameter int DATA_BYTES = 8,
  localparam int PKT_W     = ID_W + ADDR_W + 29 + USER_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [PKT_W-1:0]  DATA,
  input  logic              VALID,
  output logic              READY,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARLOCK,
  output logic [3:0]        ARCACHE,
  output logic [2:0]        ARPROT,
  output logic [3:0]        ARQOS,
  output logic [3:0]        ARREGION,
  output logic [USER_W-1:0] ARUSER,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic              PROT_ERR,
  output logic [2:0]        ERR_CODE,
  output logic [1:0]        dbg_state
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } ar_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nxt;
  ar_t    in_pkt, m_pkt, s_pkt;
  logic   valid_q, ready_q;
  logic   accept, issue, load_m, load_s, move_s;

  // Handshakes: a transfer happens on an edge where valid and ready are both high;
  // once ARVALID is up the AR outputs hold until ARREADY is seen.
  assign in_pkt = DATA;
  assign accept = VALID & ready_q;
  assign issue  = valid_q & ARREADY;

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    move_s    = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        load_m    = 1'b1;
      end
      ONE: begin
        if (accept && issue) begin
          load_m = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_s    = 1'b1;
        end else if (issue) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (issue) begin
        state_nxt = ONE;
        move_s    = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // READY stays low through reset and rises on the first edge after release.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt != EMPTY);
      ready_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (load_m)      m_pkt <= in_pkt;
    else if (move_s) m_pkt <= s_pkt;
    if (load_s)      s_pkt <= in_pkt;
  end

  assign READY     = ready_q;
  assign ARVALID   = valid_q;
  assign ARID      = m_pkt.id;
  assign ARADDR    = m_pkt.addr;
  assign ARLEN     = m_pkt.len;
  assign ARSIZE    = m_pkt.size;
  assign ARBURST   = m_pkt.burst;
  assign ARLOCK    = m_pkt.lock;
  assign ARCACHE   = m_pkt.cache;
  assign ARPROT    = m_pkt.prot;
  assign ARQOS     = m_pkt.qos;
  assign ARREGION  = m_pkt.region;
  assign ARUSER    = m_pkt.user;
  assign dbg_state = state;

`ifdef AR_FORWARD_CHECK_EN
  localparam int SIZE_LOG2 = $clog2(DATA_BYTES);
  logic [2:0]  code;
  logic [15:0] span;
  logic        prot_err_q;
  logic [2:0]  err_code_q;

  // Burst end offset within the 4KB page; 16 bits covers the worst case 4095 + 256*128.
  always_comb begin
    span = {4'd0, in_pkt.addr[11:0]} + ((16'(in_pkt.len) + 16'd1) << in_pkt.size);
    code = 3'd0;
    if (in_pkt.burst == 2'b11)
      code = 3'd1;
    else if (in_pkt.burst == 2'b10 && !(in_pkt.len == 8'd1 || in_pkt.len == 8'd3 ||
                                        in_pkt.len == 8'd7 || in_pkt.len == 8'd15))
      code = 3'd2;
    else if (int'(in_pkt.size) > SIZE_LOG2)
      code = 3'd3;
    else if (in_pkt.burst == 2'b01 && in_pkt.len > 8'd15 && in_pkt.lock)
      code = 3'd4;
    else if (in_pkt.burst == 2'b01 && span > 16'd4096)
      code = 3'd5;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      prot_err_q <= 1'b0;
      err_code_q <= 3'd0;
    end else if (accept && code != 3'd0 && !prot_err_q) begin
      prot_err_q <= 1'b1;
      err_code_q <= code;
    end
  end

  assign PROT_ERR = prot_err_q;
  assign ERR_CODE = err_code_q;
`else
  assign PROT_ERR = 1'b0;
  assign ERR_CODE = 3'd0;
`endif

endmodule

// File: tb/tb_ar_forward_slice.sv
// Randomised and directed bench for ar_forward_slice against a queue-based reference model.
module tb_ar_forward_slice;
  localparam int ID_W       = 8;
  localparam int ADDR_W     = 36;
  localparam int USER_W     = 4;
  localparam int DATA_BYTES = 8;
  localparam int PKT_W      = ID_W + ADDR_W + 29 + USER_W;

  logic              CLK = 1'b0;
  logic              RESETn = 1'b1;
  logic [PKT_W-1:0]  DATA = '0;
  logic              VALID = 1'b0;
  logic              READY;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic [3:0]        ARQOS;
  logic [3:0]        ARREGION;
  logic [USER_W-1:0] ARUSER;
  logic              ARVALID;
  logic              ARREADY = 1'b0;
  logic              PROT_ERR;
  logic [2:0]        ERR_CODE;
  logic [1:0]        dbg_state;
  logic [PKT_W-1:0]  ar_bus;

  ar_forward_slice #(.ID_W(ID_W), .ADDR_W(ADDR_W), .USER_W(USER_W), .DATA_BYTES(DATA_BYTES)) dut (
    .CLK(CLK), .RESETn(RESETn), .DATA(DATA), .VALID(VALID), .READY(READY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
    .ARREGION(ARREGION), .ARUSER(ARUSER), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .PROT_ERR(PROT_ERR), .ERR_CODE(ERR_CODE), .dbg_state(dbg_state)
  );

  assign ar_bus = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
                   ARQOS, ARREGION, ARUSER};

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [PKT_W-1:0] exp_q[$];
  logic             exp_err = 1'b0;
  logic [2:0]       exp_code = 3'd0;
  bit               seen_edge = 1'b0;
  bit               acc_n = 1'b0;
  bit               iss_n = 1'b0;
  logic [PKT_W-1:0] pkt_n = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef AR_FORWARD_CHECK_EN
  function automatic logic [2:0] code_of(input logic [PKT_W-1:0] p);
    logic [ID_W-1:0] id; logic [ADDR_W-1:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos;
    logic [3:0] region; logic [USER_W-1:0] user;
    {id, addr, len, size, burst, lock, cache, prot, qos, region, user} = p;
    if (burst == 2'b11) return 3'd1;
    if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 3'd2;
    if ((1 << size) > DATA_BYTES) return 3'd3;
    if (burst == 2'b01 && len > 8'd15 && lock) return 3'd4;
    if (burst == 2'b01 && (int'(addr % 4096) + (int'(len) + 1) * (1 << size)) > 4096) return 3'd5;
    return 3'd0;
  endfunction
`endif

  // Model: the slice holds up to two requests in FIFO order.
  always @(negedge CLK) begin
    acc_n = 1'b0;
    iss_n = 1'b0;
    if (!RESETn) begin
      chk("rst_arvalid", ARVALID, 1'b0);
      chk("rst_ready", READY, 1'b0);
      chk("rst_prot_err", PROT_ERR, 1'b0);
      chk("rst_err_code", ERR_CODE, 3'd0);
    end else begin
      chk("arvalid", ARVALID, exp_q.size() > 0);
      chk("ready", READY, seen_edge && exp_q.size() < 2);
      if (exp_q.size() > 0) chk("ar_fields", ar_bus, exp_q[0]);
      chk("prot_err", PROT_ERR, exp_err);
      chk("err_code", ERR_CODE, exp_code);
      acc_n = VALID && seen_edge && exp_q.size() < 2;
      iss_n = exp_q.size() > 0 && ARREADY;
      pkt_n = DATA;
    end
  end

  always @(posedge CLK) begin
    if (RESETn) begin
      if (iss_n) void'(exp_q.pop_front());
      if (acc_n) begin
        exp_q.push_back(pkt_n);
`ifdef AR_FORWARD_CHECK_EN
        if (!exp_err && code_of(pkt_n) != 3'd0) begin
          exp_err  = 1'b1;
          exp_code = code_of(pkt_n);
        end
`endif
      end
      seen_edge = 1'b1;
    end
    acc_n = 1'b0;
    iss_n = 1'b0;
  end

  always @(negedge RESETn) begin
    exp_q.delete();
    seen_edge = 1'b0;
    exp_err   = 1'b0;
    exp_code  = 3'd0;
    acc_n     = 1'b0;
    iss_n     = 1'b0;
  end

  function automatic logic [PKT_W-1:0] mk(input logic [7:0] id, input logic [35:0] addr,
                                          input logic [7:0] len, input logic [2:0] size,
                                          input logic [1:0] burst, input logic lock);
    return {id, addr, len, size, burst, lock, 4'h3, 3'h2, 4'h1, 4'h0, 4'hA};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [PKT_W-1:0] p);
    bit done;
    done  = 1'b0;
    DATA  = p;
    VALID = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge CLK);
      done = (READY === 1'b1);
      @(posedge CLK);
      #1;
    end
    VALID = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 64 cycles");
    end
  endtask

  initial begin
    #1 RESETn = 1'b0;
    idle(3);
    #1 RESETn = 1'b1;
    idle(1);
    chk("ready_after_release", READY, 1'b1);
    chk("arvalid_idle", ARVALID, 1'b0);

    // Single request
    ARREADY = 1'b1;
    send(mk(8'h5A, 36'h1_0000_0040, 8'd3, 3'd3, 2'b01, 1'b0));
    chk("single_arvalid", ARVALID, 1'b1);
    chk("single_id", ARID, 8'h5A);
    chk("single_addr", ARADDR, 36'h1_0000_0040);
    chk("single_len", ARLEN, 8'd3);
    chk("single_size", ARSIZE, 3'd3);
    chk("single_burst", ARBURST, 2'b01);
    chk("single_ready", READY, 1'b1);
    idle(2);

    // Back-to-back
    for (int i = 0; i < 16; i++) send(mk(8'(i + 16), 36'(i * 256), 8'd0, 3'd2, 2'b01, 1'b0));
    idle(3);

    // Backpressure
    ARREADY = 1'b0;
    send(mk(8'd1, 36'h100, 8'd0, 3'd2, 2'b01, 1'b0));
    send(mk(8'd2, 36'h200, 8'd0, 3'd2, 2'b01, 1'b0));
    chk("bp_ready_low", READY, 1'b0);
    chk("bp_head_id", ARID, 8'd1);
    fork
      send(mk(8'd3, 36'h300, 8'd0, 3'd2, 2'b01, 1'b0));
      begin
        idle(3);
        chk("bp_hold_id", ARID, 8'd1);
        chk("bp_hold_ready", READY, 1'b0);
        ARREADY = 1'b1;
      end
    join
    idle(4);

    // Checker: WRAP with bad length, then a 4KB crossing that must not overwrite the code
    send(mk(8'h20, 36'h0, 8'd5, 3'd2, 2'b10, 1'b0));
    idle(1);
`ifdef AR_FORWARD_CHECK_EN
    chk("wrap_prot_err", PROT_ERR, 1'b1);
    chk("wrap_err_code", ERR_CODE, 3'd2);
`else
    chk("wrap_prot_err", PROT_ERR, 1'b0);
`endif
    send(mk(8'h21, 36'hFF8, 8'd1, 3'd3, 2'b01, 1'b0));
    idle(1);
`ifdef AR_FORWARD_CHECK_EN
    chk("cross_err_code", ERR_CODE, 3'd2);
`else
    chk("cross_prot_err", PROT_ERR, 1'b0);
`endif
    idle(2);

    // Reset while FULL
    ARREADY = 1'b0;
    send(mk(8'h30, 36'h400, 8'd0, 3'd2, 2'b01, 1'b0));
    send(mk(8'h31, 36'h500, 8'd0, 3'd2, 2'b01, 1'b0));
    #2 RESETn = 1'b0;
    #1;
    chk("midrst_arvalid", ARVALID, 1'b0);
    chk("midrst_ready", READY, 1'b0);
    idle(2);
    #1 RESETn = 1'b1;
    ARREADY = 1'b1;
    idle(1);
    chk("postrst_ready", READY, 1'b1);
    chk("postrst_arvalid", ARVALID, 1'b0);
    idle(3);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      VALID   = 1'($urandom_range(0, 1));
      DATA    = PKT_W'({$urandom(), $urandom(), $urandom()});
      ARREADY = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    VALID   = 1'b0;
    ARREADY = 1'b1;
    idle(5);
    chk("drained_arvalid", ARVALID, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ar_forward_slice.md
Name: ar_forward_slice

Overview:
- Parametrised successor to the AR-channel separator.
- Unpacks a packed read-address bundle (DATA/VALID/READY) into individual AXI4 AR fields through a fully registered two-entry skid buffer, so timing is broken in both the forward and backward paths.
- Sits between the interconnect's packed AR routing fabric and a slave-side AR port.
- Optionally checks each accepted request for AXI4 burst-rule violations.

Parameters:
- ID_W, 8: ARID width.
- ADDR_W, 36: ARADDR width (≥12).
- USER_W, 4: ARUSER width (≥1).
- DATA_BYTES, 8: slave data-bus width in bytes (power of 2, 1..128); used only by the checker.
- PKT_W, derived = ID_W+ADDR_W+29+USER_W (77 at defaults): packed bundle width; not overridable.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- DATA  in  PKT_W  packed request, MSB→LSB: ARID, ARADDR, ARLEN[8], ARSIZE[3], ARBURST[2], ARLOCK[1], ARCACHE[4], ARPROT[3], ARQOS[4], ARREGION[4], ARUSER.
- VALID  in  1  DATA valid.
- READY  out  1  slice can accept; registered.
- ARID  out  ID_W
- ARADDR  out  ADDR_W
- ARLEN  out  8
- ARSIZE  out  3
- ARBURST  out  2
- ARLOCK  out  1
- ARCACHE  out  4
- ARPROT  out  3
- ARQOS  out  4
- ARREGION  out  4
- ARUSER  out  USER_W
- ARVALID  out  1  registered.
- ARREADY  in  1
- PROT_ERR  out  1  sticky error flag (checker).
- ERR_CODE  out  3  first-error cause (checker).

Behaviour:
- Clock and reset: one clock CLK; reset RESETn is asynchronous, active-low.
- Storage: main register M (drives the AR outputs) and skid register S, each PKT_W bits plus a valid bit.
- Events: accept = VALID & READY. Issue = ARVALID & ARREADY.
- States:
  - EMPTY: M and S invalid. ARVALID=0, READY=1.
  - ONE: M valid, S invalid. ARVALID=1, READY=1.
  - FULL: both valid. ARVALID=1, READY=0.
- Transitions:
  - EMPTY + accept → ONE; DATA loads into M.
  - ONE + accept & issue → ONE; DATA loads into M.
  - ONE + accept & !issue → FULL; DATA loads into S.
  - ONE + !accept & issue → EMPTY.
  - FULL + issue → ONE; S moves to M. READY rises the next cycle.
  - FULL + !issue → FULL; all outputs hold stable (AXI rule: no change while ARVALID & !ARREADY).
- Latency: accept at edge N → ARVALID high from edge N. Request is visible one cycle after it is presented.
- Throughput: one request per cycle sustained when ARREADY is held high.
- Ordering: strict FIFO. Every request is forwarded exactly once.
- Data registers: not reset. Outputs are X-don't-care while ARVALID=0.
- Reset values: ARVALID=0, state EMPTY, PROT_ERR=0, ERR_CODE=0.
  - READY=0 while RESETn low; READY=1 from the first CLK edge after release.
- Reset mid-operation: both entries are dropped immediately. No request is issued after reset.
- VALID deasserting without acceptance is tolerated; nothing is captured.

Optional Feature:
- Macro: AR_FORWARD_CHECK_EN.
- When defined, each accepted request is checked on DATA fields in the accept cycle. Priority, highest first:
  - Code 1: ARBURST==2'b11.
  - Code 2: WRAP with ARLEN not in {1,3,7,15}.
  - Code 3: ARSIZE > log2(DATA_BYTES).
  - Code 4: INCR with ARLEN>15 while ARLOCK=1.
  - Code 5: INCR crossing a 4KB boundary, i.e. ADDR[11:0] + ((ARLEN+1)<<ARSIZE) > 4096, computed in 16 bits.
- First error sets PROT_ERR (sticky until reset) and latches ERR_CODE one cycle after the accept. Later errors do not overwrite ERR_CODE.
- Erroneous requests are still forwarded unmodified.
- When not defined: no checker logic; PROT_ERR and ERR_CODE are tied 0.

Test Plan:
- Single request: ID=8'h5A, ADDR=36'h1_0000_0040, LEN=3, SIZE=3, INCR, ARREADY=1 → ARVALID high one cycle after accept, all fields exact, READY stays 1.
- Back-to-back: 16 requests with incrementing IDs, ARREADY=1 → 16 consecutive ARVALID cycles, in order, no bubbles.
- Backpressure: ARREADY=0 for 5 cycles while pushing IDs 1,2,3 → READY drops after ID 2 (FULL), ID 3 waits. Outputs are stable on ID 1. On ARREADY=1, IDs issue 1,2,3.
- Random VALID/ARREADY for 10k cycles against a scoreboard → no loss, duplication or reorder; AR outputs stable while stalled.
- Reset asserted in FULL state → ARVALID=0 immediately; after release, READY=1 from the first edge and no stale request is issued.
- With AR_FORWARD_CHECK_EN:
  - WRAP, LEN=5 → PROT_ERR=1, ERR_CODE=2.
  - Then INCR, ADDR=12'hFF8, LEN=1, SIZE=3 (crosses 4KB) → ERR_CODE stays 2.
  - Without the macro, the same stimulus → PROT_ERR=0.
